opc7_bus_responder: RTL and testbench
=====================================

# opc7_bus_responder

Memory and I/O responder for the opc7 processor bus. It decodes each processor cycle (address, rnw, vpa/vda/vio), serves instruction/data words from on-chip synchronous RAM with a programmable wait count, and serves a small I/O register file holding an interval timer and software interrupt bits. It drives the processor's clken (stall) and int_b inputs and sits between the CPU core and the rest of the system at top level.

## Interface
- MEM_AW, 12: RAM word-address width; RAM holds 2^MEM_AW 32-bit words at word addresses 0..2^MEM_AW-1.
- RAM_WAIT, 1: stall cycles per RAM access; legal range 1..15.
- TIMER_W, 24: timer counter width.
- clk  in  1  single clock; all state on rising edge.
- reset_b  in  1  asynchronous active-low reset.
- address  in  20  CPU word address.
- cpu_dout  in  32  CPU write data.
- rnw  in  1  1 = read, 0 = write.
- vpa  in  1  instruction fetch (memory space).
- vda  in  1  data access (memory space).
- vio  in  1  I/O space access; address[7:0] selects the register.
- cpu_din  out  32  read data to CPU.
- clken  out  1  CPU clock enable; low stalls the CPU.
- int_b  out  2  active-low interrupt requests to CPU.

## Operation
- Access classes: mem = (vpa|vda)&!vio; io = vio; none = no strobe. none cycles complete immediately (clken=1).
- Responder FSM: IDLE, WAIT.
  - IDLE, mem, address[19:MEM_AW]==0: clken=0, RAM read issued at address[MEM_AW-1:0]; go WAIT, cnt<=RAM_WAIT-1.
  - IDLE, mem, address out of range: clken=1, cpu_din=0, writes dropped; stay IDLE.
  - IDLE, io or none: clken=1; stay IDLE.
  - WAIT, cnt!=0: clken=0, cnt<=cnt-1.
  - WAIT, cnt==0: clken=1, cpu_din=registered RAM output; if !rnw, RAM written with cpu_dout this cycle; go IDLE.
- CPU holds address/rnw/strobes/cpu_dout stable while clken=0; responder samples them live and does not latch them.
- cpu_din: RAM data in WAIT, I/O read data when io, else 0.
- I/O map (address[7:0]); I/O writes take effect on the clk edge where clken=1 and !rnw:
  - 0x00 CTRL rw: bit0 timer enable, bit1 timer interrupt enable, bit2 timer line select (0 = int_b[0], 1 = int_b[1]).
  - 0x01 RELOAD rw: writing loads both RELOAD and COUNT.
  - 0x02 COUNT ro.
  - 0x03 STATUS: bit0 timer pending; writing 1 to bit0 clears it.
  - 0x04 SWINT rw: bits1:0 software interrupt requests.
  - Other offsets: read 0; writes ignored.
- Timer: free-running on clk, independent of clken. When enabled: COUNT==0 → COUNT<=RELOAD and pending<=1; otherwise COUNT-=1. RELOAD=0 sets pending every cycle.
- int_b[n] = !(SWINT[n] | (pending & CTRL.bit1 & CTRL.bit2==n)).

## Timing
- RAM access: RAM_WAIT+1 cycles, with clken low for the first RAM_WAIT cycles. I/O and none accesses: 1 cycle with no stall.
- Reset (async assert): FSM IDLE, cnt 0, CTRL/RELOAD/COUNT/STATUS/SWINT 0, clken forced 1, cpu_din 0, int_b 2'b11. RAM contents are not reset.
- Reset mid-WAIT: a pending write is never committed.
- A STATUS clear and a timer expiry in the same cycle: set wins, pending=1.
- A RELOAD write and an expiry in the same cycle: the write wins; COUNT=new value.
- int_b changes one cycle after the causing register update; there is no combinational path from cpu_dout.

## Structure
- Package opc7_bus_pkg: I/O offset constants (IO_CTRL..IO_SWINT), CTRL bit indices, FSM state enum.
- Sub-module opc7_sram: single-port synchronous RAM with registered read and write enable, parameterised by MEM_AW; inferable as block RAM.
- Address decode, FSM, timer and I/O registers live in opc7_bus_responder.

## Test plan
- RAM_WAIT=1: write 0xDEADBEEF to 0x00010, then read 0x00010 → clken low exactly 1 cycle per access; read returns 0xDEADBEEF.
- RAM_WAIT=3: fetch (vpa) from 0x00000 → clken low 3 cycles, high on the 4th cycle with data.
- Out-of-range read at 0x80000 with MEM_AW=12 → no stall, cpu_din=0; a write there leaves RAM unchanged.
- Timer: RELOAD=4, CTRL=0x3 → pending set every 5 clks; int_b=2'b10; STATUS write 1 → int_b=2'b11 until the next expiry; a clear coinciding with an expiry leaves pending=1.
- SWINT=2'b10 → int_b=2'b01 one cycle later; CTRL.bit2=1 with timer pending → int_b[1] low from either source.
- Async reset asserted in WAIT during a write to 0x00020 → word unchanged, clken=1, int_b=2'b11, all I/O registers read 0.

Source files
------------

// File: rtl/opc7_bus_pkg.sv
// Shared constants and types for the opc7 bus responder: I/O register
// offsets, CTRL bit positions and the responder FSM state encoding.
package opc7_bus_pkg;

    // I/O register offsets (address[7:0])
    localparam logic [7:0] IO_CTRL   = 8'h00;
    localparam logic [7:0] IO_RELOAD = 8'h01;
    localparam logic [7:0] IO_COUNT  = 8'h02;
    localparam logic [7:0] IO_STATUS = 8'h03;
    localparam logic [7:0] IO_SWINT  = 8'h04;

    // CTRL register bit indices
    localparam int CTRL_EN  = 0;  // timer enable
    localparam int CTRL_IE  = 1;  // timer interrupt enable
    localparam int CTRL_SEL = 2;  // timer interrupt line select

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } resp_state_e;

endpackage

// File: rtl/opc7_sram.sv
// Single-port synchronous RAM, 32-bit words, registered read output.
// Read-before-write: a write cycle returns the old word on rdata_o.
module opc7_sram #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(2**MEM_AW)-1];
    logic [31:0] rdata_q;

    // Array write and registered read, shaped for block RAM inference
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/opc7_bus_responder.sv
// opc7 bus responder: decodes processor cycles, serves RAM with a fixed
// wait count, and hosts the timer / software-interrupt I/O registers.
module opc7_bus_responder
    import opc7_bus_pkg::*;
#(
    parameter int MEM_AW   = 12,
    parameter int RAM_WAIT = 1,
    parameter int TIMER_W  = 24
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [19:0] address,
    input  logic [31:0] cpu_dout,
    input  logic        rnw,
    input  logic        vpa,
    input  logic        vda,
    input  logic        vio,
    output logic [31:0] cpu_din,
    output logic        clken,
    output logic [1:0]  int_b
);

    resp_state_e        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               is_mem, is_io, in_range;
    logic               ram_we, clken_c;
    logic [31:0]        ram_rdata, io_rdata;
    logic [7:0]         io_off;
    logic               io_wr;

    logic [2:0]         ctrl_q, ctrl_d;
    logic [TIMER_W-1:0] reload_q, reload_d;
    logic [TIMER_W-1:0] count_q, count_d;
    logic               pending_q, pending_d;
    logic [1:0]         swint_q, swint_d;
    logic [1:0]         int_b_q, int_b_d;
    logic               timer_fire, status_clr;

    assign is_io    = vio;
    assign is_mem   = (vpa | vda) & ~vio;
    assign in_range = (address[19:MEM_AW] == '0);
    assign io_off   = address[7:0];
    // I/O cycles never stall, so any io write seen in IDLE completes this edge
    assign io_wr    = (state_q == ST_IDLE) & is_io & ~rnw;

    opc7_sram #(
        .MEM_AW (MEM_AW)
    ) u_sram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (address[MEM_AW-1:0]),
        .wdata_i (cpu_dout),
        .rdata_o (ram_rdata)
    );

    // Responder FSM next-state, stall and RAM write-enable decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clken_c = 1'b1;
        ram_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (is_mem && in_range) begin
                    clken_c = 1'b0;
                    state_d = ST_WAIT;
                    cnt_d   = 4'(RAM_WAIT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    clken_c = 1'b0;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    // Write commits only on the completing edge, so a reset
                    // during the stall discards it
                    ram_we  = ~rnw;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign timer_fire = ctrl_q[CTRL_EN] && (count_q == '0);
    assign status_clr = io_wr && (io_off == IO_STATUS) && cpu_dout[0];

    // Timer and I/O register next-state; RELOAD write beats expiry, expiry beats clear
    always_comb begin
        ctrl_d    = ctrl_q;
        reload_d  = reload_q;
        count_d   = count_q;
        swint_d   = swint_q;
        pending_d = timer_fire | (pending_q & ~status_clr);
        if (ctrl_q[CTRL_EN]) begin
            count_d = timer_fire ? reload_q : count_q - 1'b1;
        end
        if (io_wr) begin
            unique case (io_off)
                IO_CTRL:   ctrl_d  = cpu_dout[2:0];
                IO_RELOAD: begin
                    reload_d = cpu_dout[TIMER_W-1:0];
                    count_d  = cpu_dout[TIMER_W-1:0];
                end
                IO_SWINT:  swint_d = cpu_dout[1:0];
                default:   ;
            endcase
        end
    end

    // Interrupt lines derive from registered state only, one cycle behind it
    for (genvar gi = 0; gi < 2; gi++) begin : g_intb
        assign int_b_d[gi] = ~(swint_q[gi] |
                               (pending_q & ctrl_q[CTRL_IE] & (ctrl_q[CTRL_SEL] == 1'(gi))));
    end

    // Timer, I/O registers and interrupt outputs
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ctrl_q    <= '0;
            reload_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            swint_q   <= '0;
            int_b_q   <= 2'b11;
        end else begin
            ctrl_q    <= ctrl_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            swint_q   <= swint_d;
            int_b_q   <= int_b_d;
        end
    end

    // I/O read mux
    always_comb begin
        io_rdata = '0;
        unique case (io_off)
            IO_CTRL:   io_rdata = 32'(ctrl_q);
            IO_RELOAD: io_rdata = 32'(reload_q);
            IO_COUNT:  io_rdata = 32'(count_q);
            IO_STATUS: io_rdata = 32'(pending_q);
            IO_SWINT:  io_rdata = 32'(swint_q);
            default:   io_rdata = '0;
        endcase
    end

    // Read data steering; forced quiet while reset is held
    always_comb begin
        cpu_din = '0;
        if (reset_b) begin
            if (state_q == ST_WAIT) begin
                cpu_din = ram_rdata;
            end else if (is_io) begin
                cpu_din = io_rdata;
            end
        end
    end

    assign clken = clken_c | ~reset_b;
    assign int_b = int_b_q;

endmodule

// File: tb/tb_opc7_bus_responder.sv
// Bench for opc7_bus_responder: two instances (RAM_WAIT=1 and 3), a
// scoreboard queue per instance filled at issue time, and a monitor that
// pops whenever a bus cycle completes (clken high with a cycle on the bus).
module tb_opc7_bus_responder;

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          stalls;
        int          kind;
        logic [19:0] addr;
        logic        rnw;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [19:0] addr_a  [2];
    logic [31:0] dout_a  [2];
    logic        rnw_a   [2];
    logic        vpa_a   [2];
    logic        vda_a   [2];
    logic        vio_a   [2];
    logic [31:0] din_a   [2];
    logic        clken_a [2];
    logic [1:0]  intb_a  [2];

    // Reference state
    logic [2:0]  m_ctrl [2];
    logic [23:0] m_rel  [2];
    logic [23:0] m_cnt  [2];
    logic        m_pend [2];
    logic [1:0]  m_sw   [2];
    logic [1:0]  m_intb [2];
    logic [31:0] mem_m [int];

    exp_t q0[$];
    exp_t q1[$];
    bit   act [2];
    int   stall_c [2];
    bit   mon_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        opc7_bus_responder #(
            .MEM_AW   (12),
            .RAM_WAIT ((gi == 0) ? 1 : 3),
            .TIMER_W  (24)
        ) u_dut (
            .clk      (clk),
            .reset_b  (reset_b),
            .address  (addr_a[gi]),
            .cpu_dout (dout_a[gi]),
            .rnw      (rnw_a[gi]),
            .vpa      (vpa_a[gi]),
            .vda      (vda_a[gi]),
            .vio      (vio_a[gi]),
            .cpu_din  (din_a[gi]),
            .clken    (clken_a[gi]),
            .int_b    (intb_a[gi])
        );
    end

    function automatic void check(string nm, logic [31:0] got, logic [31:0] req);
        n_total++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got %08h required %08h", nm, got, req);
    endfunction

    function automatic bit wr_at(int d, logic [7:0] off);
        return vio_a[d] && !rnw_a[d] && (addr_a[d][7:0] == off);
    endfunction

    // Interrupt lines as the register state says they should be
    function automatic logic [1:0] intb_of(int d);
        logic [1:0] r;
        for (int n = 0; n < 2; n++) begin
            r[n] = !(m_sw[d][n] || (m_pend[d] && m_ctrl[d][1] && (int'(m_ctrl[d][2]) == n)));
        end
        return r;
    endfunction

    function automatic logic [31:0] io_model(int d, logic [7:0] off);
        case (off)
            8'h00:   return {29'b0, m_ctrl[d]};
            8'h01:   return {8'b0, m_rel[d]};
            8'h02:   return {8'b0, m_cnt[d]};
            8'h03:   return {31'b0, m_pend[d]};
            8'h04:   return {30'b0, m_sw[d]};
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural register/timer model, one update per clock
    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int d = 0; d < 2; d++) begin
                m_ctrl[d] <= '0; m_rel[d] <= '0; m_cnt[d] <= '0;
                m_pend[d] <= 1'b0; m_sw[d] <= '0; m_intb[d] <= 2'b11;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_intb[d] <= intb_of(d);
                m_ctrl[d] <= wr_at(d, 8'h00) ? dout_a[d][2:0] : m_ctrl[d];
                m_rel[d]  <= wr_at(d, 8'h01) ? dout_a[d][23:0] : m_rel[d];
                if (wr_at(d, 8'h01)) m_cnt[d] <= dout_a[d][23:0];
                else if (m_ctrl[d][0]) m_cnt[d] <= (m_cnt[d] == 0) ? m_rel[d] : m_cnt[d] - 24'd1;
                m_pend[d] <= (m_ctrl[d][0] && m_cnt[d] == 0) ||
                             (m_pend[d] && !(wr_at(d, 8'h03) && dout_a[d][0]));
                m_sw[d]   <= wr_at(d, 8'h04) ? dout_a[d][1:0] : m_sw[d];
            end
        end
    end

    // Monitor: int_b every cycle, scoreboard pop on each completed cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("int_b dut%0d", d), 32'(intb_a[d]), 32'(m_intb[d]));
                    if (act[d]) begin
                        if (!clken_a[d]) begin
                            stall_c[d]++;
                        end else begin
                            if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                                n_total++;
                                $display("FAIL scoreboard_empty dut%0d: got completion required none", d);
                            end else begin
                                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                                check($sformatf("stalls dut%0d @%05h", d, e.addr), stall_c[d], e.stalls);
                                if (e.chk) check($sformatf("cpu_din dut%0d @%05h", d, e.addr), din_a[d], e.data);
                                $display("dut%0d kind=%0d rnw=%0d addr=%05h din=%08h stalls=%0d",
                                         d, e.kind, e.rnw, e.addr, din_a[d], stall_c[d]);
                            end
                            stall_c[d] = 0;
                        end
                    end
                end
            end
        end
    end

    // kind: 0 none, 1 data (vda), 2 fetch (vpa), 3 io (vio)
    task automatic do_txn(input int d, input int kind, input logic [19:0] a,
                          input logic [31:0] wd, input logic r);
        exp_t e;
        int   key;
        bit   done;
        e.data = 32'h0; e.chk = 1'b1; e.stalls = 0; e.kind = kind; e.addr = a; e.rnw = r;
        key = d * 4096 + int'(a[11:0]);
        if ((kind == 1 || kind == 2) && a[19:12] == 8'h00) begin
            e.stalls = (d == 0) ? 1 : 3;
            if (r) begin
                e.chk = mem_m.exists(key) ? 1'b1 : 1'b0;
                if (e.chk) e.data = mem_m[key];
            end else begin
                e.chk = 1'b0;
                mem_m[key] = wd;
            end
        end else if (kind == 3) begin
            e.data = io_model(d, a[7:0]);
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        addr_a[d] = a; dout_a[d] = wd; rnw_a[d] = (kind == 0) ? 1'b1 : r;
        vpa_a[d] = (kind == 2); vda_a[d] = (kind == 1); vio_a[d] = (kind == 3);
        act[d] = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = clken_a[d];
        end
        if (!done) begin
            n_total++;
            $display("FAIL txn_timeout dut%0d @%05h: clken stayed 0 required 1 within 20 cycles", d, a);
        end
        @(posedge clk); #1;
        act[d] = 1'b0; vpa_a[d] = 1'b0; vda_a[d] = 1'b0; vio_a[d] = 1'b0; rnw_a[d] = 1'b1;
    endtask

    task automatic idle(input int d, input int n);
        for (int k = 0; k < n; k++) do_txn(d, 0, 20'h0, 32'h0, 1'b1);
    endtask

    initial begin
        int          k;
        logic [19:0] a;
        logic [31:0] wd;
        logic [7:0]  off;
        int          kind;

        for (int d = 0; d < 2; d++) begin
            addr_a[d] = '0; dout_a[d] = '0; rnw_a[d] = 1'b1;
            vpa_a[d] = 1'b0; vda_a[d] = 1'b0; vio_a[d] = 1'b0;
            act[d] = 1'b0; stall_c[d] = 0;
        end
        reset_b = 1'b0;
        // In-range access requested while reset is held: must not stall
        addr_a[0] = 20'h00010; vda_a[0] = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset clken dut%0d", d), 32'(clken_a[d]), 32'h1);
            check($sformatf("reset int_b dut%0d", d), 32'(intb_a[d]), 32'h3);
            check($sformatf("reset cpu_din dut%0d", d), din_a[d], 32'h0);
        end
        vda_a[0] = 1'b0;
        @(negedge clk); reset_b = 1'b1; mon_en = 1'b1;
        @(posedge clk); #1;

        // RAM write/read with one wait state
        do_txn(0, 1, 20'h00010, 32'hDEADBEEF, 1'b0);
        do_txn(0, 1, 20'h00010, 32'h0, 1'b1);
        // Out-of-range accesses: no stall, zero data, write dropped
        do_txn(0, 1, 20'h80000, 32'h0, 1'b1);
        do_txn(0, 1, 20'h80010, 32'h12345678, 1'b0);
        do_txn(0, 1, 20'h00010, 32'h0, 1'b1);
        do_txn(0, 1, 20'h00FFF, 32'hCAFEF00D, 1'b0);
        do_txn(0, 2, 20'h00FFF, 32'h0, 1'b1);
        // Three wait states, instruction fetch
        do_txn(1, 1, 20'h00000, 32'h600DF00D, 1'b0);
        do_txn(1, 2, 20'h00000, 32'h0, 1'b1);

        // Timer: RELOAD=4, enable with interrupt on line 0
        do_txn(0, 3, 20'h00001, 32'd4, 1'b0);
        do_txn(0, 3, 20'h00000, 32'h3, 1'b0);
        for (k = 0; k < 12 && intb_a[0] != 2'b10; k++) idle(0, 1);
        check("timer int_b low", 32'(intb_a[0]), 32'h2);
        idle(0, 6);
        do_txn(0, 3, 20'h00003, 32'h0, 1'b1);
        // Clear away from an expiry
        for (k = 0; k < 12 && m_cnt[0] != 24'd2; k++) idle(0, 1);
        do_txn(0, 3, 20'h00003, 32'h1, 1'b0);
        idle(0, 1);
        check("cleared int_b", 32'(intb_a[0]), 32'h3);
        idle(0, 4);
        // Clear on the same edge as an expiry: pending must survive
        for (k = 0; k < 12 && m_cnt[0] != 24'd0; k++) idle(0, 1);
        do_txn(0, 3, 20'h00003, 32'h1, 1'b0);
        do_txn(0, 3, 20'h00003, 32'h0, 1'b1);
        do_txn(0, 3, 20'h00002, 32'h0, 1'b1);

        // Software interrupt with timer interrupt disabled
        do_txn(0, 3, 20'h00000, 32'h0, 1'b0);
        do_txn(0, 3, 20'h00003, 32'h1, 1'b0);
        idle(0, 1);
        do_txn(0, 3, 20'h00004, 32'h2, 1'b0);
        check("swint before", 32'(intb_a[0]), 32'h3);
        @(posedge clk); #1;
        check("swint after", 32'(intb_a[0]), 32'h1);
        do_txn(0, 3, 20'h00004, 32'h0, 1'b0);
        // Timer routed to line 1
        do_txn(0, 3, 20'h00000, 32'h7, 1'b0);
        for (k = 0; k < 12 && intb_a[0] != 2'b01; k++) idle(0, 1);
        check("timer line1", 32'(intb_a[0]), 32'h1);
        do_txn(0, 3, 20'h00000, 32'h0, 1'b0);
        do_txn(0, 3, 20'h00003, 32'h1, 1'b0);

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 120; i++) begin
                kind = $urandom_range(0, 3);
                wd = $urandom;
                case ($urandom_range(0, 3))
                    0:       a = 20'h00FFF;
                    1:       a = {8'($urandom_range(1, 255)), 12'($urandom_range(0, 15))};
                    default: a = {8'h00, 12'($urandom_range(0, 15))};
                endcase
                if (kind == 3) begin
                    off = 8'($urandom_range(0, 7));
                    a = {12'h000, off};
                    if (off == 8'h01) wd = 32'($urandom_range(0, 6));
                end
                do_txn(d, kind, a, wd, (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1)));
            end
        end

        // Reset during the stall of a write
        do_txn(1, 1, 20'h00020, 32'hA5A50001, 1'b0);
        mon_en = 1'b0;
        addr_a[1] = 20'h00020; dout_a[1] = 32'h5A5A0002; rnw_a[1] = 1'b0; vda_a[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("stall before reset", 32'(clken_a[1]), 32'h0);
        reset_b = 1'b0;
        #1;
        check("reset mid-wait clken", 32'(clken_a[1]), 32'h1);
        check("reset mid-wait cpu_din", din_a[1], 32'h0);
        check("reset mid-wait int_b0", 32'(intb_a[0]), 32'h3);
        check("reset mid-wait int_b1", 32'(intb_a[1]), 32'h3);
        @(posedge clk); #1;
        vda_a[1] = 1'b0; rnw_a[1] = 1'b1;
        @(negedge clk);
        reset_b = 1'b1;
        stall_c[0] = 0; stall_c[1] = 0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        do_txn(1, 1, 20'h00020, 32'h0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            for (int o = 0; o < 5; o++) do_txn(d, 3, 20'(o), 32'h0, 1'b1);
        end
        idle(0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
